// File: rtl/reg_sequencer_if.sv
// ---------------------------------------------------------------------------
// reg_sequencer_if
//   Bundles the instruction handshake and the register-file side signals of
//   reg_sequencer.
//
//   Handshake: an instruction transfers on a rising clk edge where
//   instr_valid=1 and instr_ready=1. instr_ready depends only on sequencer
//   state, never on instr_valid. When instr_ready=0, instr_valid and instr are
//   ignored.
//
//   Signals:
//     instr_valid / instr[15:0] / instr_ready    instruction handshake
//     rf_read_p_1, rf_read_p_2 [2:0], rf_r1, rf_r2  register-file read port
//     rf_read_data1, rf_read_data2 [7:0]         read data, one edge after enable
//     rf_write_p[2:0], rf_w, rf_write_data[7:0]  register-file write port
//     flag_zero, flag_carry                      ALU status
//     done                                       one-cycle retire pulse
//
//   Modports:
//     slave  - the sequencer
//     master - the instruction source plus the register file
// ---------------------------------------------------------------------------
interface reg_sequencer_if;
  logic        instr_valid;
  logic [15:0] instr;
  logic        instr_ready;
  logic [2:0]  rf_read_p_1;
  logic [2:0]  rf_read_p_2;
  logic        rf_r1;
  logic        rf_r2;
  logic [2:0]  rf_write_p;
  logic        rf_w;
  logic [7:0]  rf_write_data;
  logic [7:0]  rf_read_data1;
  logic [7:0]  rf_read_data2;
  logic        flag_zero;
  logic        flag_carry;
  logic        done;

  modport slave (
    input  instr_valid, instr, rf_read_data1, rf_read_data2,
    output instr_ready, rf_read_p_1, rf_read_p_2, rf_r1, rf_r2,
           rf_write_p, rf_w, rf_write_data, flag_zero, flag_carry, done
  );

  modport master (
    output instr_valid, instr, rf_read_data1, rf_read_data2,
    input  instr_ready, rf_read_p_1, rf_read_p_2, rf_r1, rf_r2,
           rf_write_p, rf_w, rf_write_data, flag_zero, flag_carry, done
  );
endinterface

// File: rtl/reg_sequencer.sv
// ---------------------------------------------------------------------------
// reg_sequencer
//   Sequences one 16-bit instruction at a time against an external 8x8
//   register file with registered reads.
//   Fields: op=[15:13] rd=[12:10] rs1=[9:7] rs2=[6:4] imm8=[7:0].
//   Ops: NOP ADD SUB AND OR XOR LDI MOV.
//   Flow: IDLE -> ISSUE -> EXEC -> WB -> IDLE (ALU ops, MOV)
//         IDLE -> WB -> IDLE                  (LDI, NOP)
//
//   Ports:
//     clk          rising-edge clock
//     reset        asynchronous, active-high reset
//     bus          reg_sequencer_if.slave (handshake + register-file port)
//     dbg_state_o  current FSM state (0 IDLE, 1 ISSUE, 2 EXEC, 3 WB)
// ---------------------------------------------------------------------------
module reg_sequencer (
  input  logic                  clk,
  input  logic                  reset,
  reg_sequencer_if.slave        bus,
  output logic [1:0]            dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_e;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_SUB = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LDI = 3'b110;
  localparam logic [2:0] OP_MOV = 3'b111;

  state_e      state_q, state_d;
  logic [15:0] instr_q, instr_d;
  logic [7:0]  result_q, result_d;
  logic        zf_q, zf_d;
  logic        cf_q, cf_d;
  // Address/data outputs hold their last driven value outside ISSUE/WB.
  logic [2:0]  p1_q, p1_d;
  logic [2:0]  p2_q, p2_d;
  logic [2:0]  wp_q, wp_d;
  logic [7:0]  wdata_q, wdata_d;

  logic [2:0]  op, rd, rs1, rs2, in_op, free_p;
  logic [7:0]  imm8, opa, opb;
  logic [8:0]  sum, diff;

  assign op    = instr_q[15:13];
  assign rd    = instr_q[12:10];
  assign rs1   = instr_q[9:7];
  assign rs2   = instr_q[6:4];
  assign imm8  = instr_q[7:0];
  assign in_op = bus.instr[15:13];
  assign opa   = bus.rf_read_data1;
  assign opb   = bus.rf_read_data2;

  // 9-bit arithmetic: sum[8] is the carry, diff[8] is the borrow (a < b).
  assign sum  = {1'b0, opa} + {1'b0, opb};
  assign diff = {1'b0, opa} - {1'b0, opb};

  // The register file drops a read whose address equals rf_write_p, so while
  // reading, park the write address on a register neither source uses.
  always_comb begin
    if (rs1 != 3'd0 && rs2 != 3'd0)      free_p = 3'd0;
    else if (rs1 != 3'd1 && rs2 != 3'd1) free_p = 3'd1;
    else                                 free_p = 3'd2;
  end

  always_comb begin
    state_d         = state_q;
    instr_d         = instr_q;
    result_d        = result_q;
    zf_d            = zf_q;
    cf_d            = cf_q;
    p1_d            = p1_q;
    p2_d            = p2_q;
    wp_d            = wp_q;
    wdata_d         = wdata_q;
    bus.rf_r1       = 1'b0;
    bus.rf_r2       = 1'b0;
    bus.rf_w        = 1'b0;
    bus.done        = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.instr_valid) begin
          instr_d = bus.instr;
          state_d = (in_op == OP_NOP || in_op == OP_LDI) ? WB : ISSUE;
        end
      end
      ISSUE: begin
        p1_d      = rs1;
        p2_d      = rs2;
        wp_d      = free_p;
        bus.rf_r1 = 1'b1;
        bus.rf_r2 = (op != OP_MOV);
        state_d   = EXEC;
      end
      EXEC: begin
        // Flags move only for the arithmetic/logic ops; MOV copies operand a.
        case (op)
          OP_ADD: begin result_d = sum[7:0];  cf_d = sum[8];  zf_d = (sum[7:0] == 8'd0);  end
          OP_SUB: begin result_d = diff[7:0]; cf_d = diff[8]; zf_d = (diff[7:0] == 8'd0); end
          OP_AND: begin result_d = opa & opb; cf_d = 1'b0; zf_d = ((opa & opb) == 8'd0); end
          OP_OR:  begin result_d = opa | opb; cf_d = 1'b0; zf_d = ((opa | opb) == 8'd0); end
          OP_XOR: begin result_d = opa ^ opb; cf_d = 1'b0; zf_d = ((opa ^ opb) == 8'd0); end
          OP_MOV: result_d = opa;
          default: ;
        endcase
        state_d = WB;
      end
      WB: begin
        wp_d     = rd;
        wdata_d  = (op == OP_LDI) ? imm8 : result_q;
        bus.rf_w = (op != OP_NOP);
        bus.done = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      instr_q  <= 16'd0;
      result_q <= 8'd0;
      zf_q     <= 1'b0;
      cf_q     <= 1'b0;
      p1_q     <= 3'd0;
      p2_q     <= 3'd0;
      wp_q     <= 3'd0;
      wdata_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      instr_q  <= instr_d;
      result_q <= result_d;
      zf_q     <= zf_d;
      cf_q     <= cf_d;
      p1_q     <= p1_d;
      p2_q     <= p2_d;
      wp_q     <= wp_d;
      wdata_q  <= wdata_d;
    end
  end

  assign bus.instr_ready   = (state_q == IDLE) && !reset;
  assign bus.rf_read_p_1   = p1_d;
  assign bus.rf_read_p_2   = p2_d;
  assign bus.rf_write_p    = wp_d;
  assign bus.rf_write_data = wdata_d;
  assign bus.flag_zero     = zf_q;
  assign bus.flag_carry    = cf_q;
  assign dbg_state_o       = state_q;

endmodule

// File: tb/tb_reg_sequencer.sv
// ---------------------------------------------------------------------------
// tb_reg_sequencer
//   Directed bench for reg_sequencer with a behavioural 8x8 register file
//   (registered reads, read suppressed when its address equals rf_write_p).
// ---------------------------------------------------------------------------
module tb_reg_sequencer;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] dbg_state;
  int         errors = 0;
  int         checks = 0;

  reg_sequencer_if bus();

  reg_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // ---- clock ----
  always #5 clk = ~clk;

  // ---- register file model ----
  logic [7:0] regs [8] = '{default: 8'hEE};

  always @(posedge clk) begin
    if (bus.rf_r1 && bus.rf_read_p_1 != bus.rf_write_p) bus.rf_read_data1 <= regs[bus.rf_read_p_1];
    if (bus.rf_r2 && bus.rf_read_p_2 != bus.rf_write_p) bus.rf_read_data2 <= regs[bus.rf_read_p_2];
    if (bus.rf_w) regs[bus.rf_write_p] <= bus.rf_write_data;
  end

  // ---- monitor (counts pulses, records ISSUE-cycle outputs) ----
  int         done_cnt = 0;
  int         w_cnt    = 0;
  logic [2:0] iss_wp;
  logic [2:0] iss_p1;
  logic       iss_r1;
  logic       iss_r2;

  always @(negedge clk) begin
    if (bus.done) done_cnt++;
    if (bus.rf_w) w_cnt++;
    if (dbg_state == 2'd1) begin
      iss_wp = bus.rf_write_p;
      iss_p1 = bus.rf_read_p_1;
      iss_r1 = bus.rf_r1;
      iss_r2 = bus.rf_r2;
    end
  end

  // ---- encoders ----
  function automatic logic [15:0] alu(input logic [2:0] op, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2);
    return {op, rd, rs1, rs2, 4'b0000};
  endfunction

  function automatic logic [15:0] ldi(input logic [2:0] rd, input logic [7:0] imm);
    return {3'b110, rd, 2'b00, imm};
  endfunction

  // ---- driver: call at a negedge with the DUT idle; returns at the first
  // negedge where instr_ready is back, busy = cycles with instr_ready=0 ----
  task automatic run_instr(input logic [15:0] w, input bit hold, output int busy);
    bus.instr_valid = 1'b1;
    bus.instr       = w;
    @(posedge clk);
    #1;
    if (!hold) bus.instr_valid = 1'b0;
    busy = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (bus.instr_ready) break;
      busy++;
      if (hold) bus.instr = 16'($urandom_range(0, 65535));
    end
    bus.instr_valid = 1'b0;
  endtask

  // ---- tests ----
  task automatic test_reset;
    bus.instr_valid = 1'b0;
    bus.instr       = 16'h0000;
    reset           = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.instr_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got=%b exp=0", bus.instr_ready); end
    checks++; if ({bus.rf_r1, bus.rf_r2, bus.rf_w, bus.done} !== 4'b0000) begin errors++; $display("FAIL reset_strobes got=%b exp=0000", {bus.rf_r1, bus.rf_r2, bus.rf_w, bus.done}); end
    checks++; if ({bus.flag_zero, bus.flag_carry} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b exp=00", {bus.flag_zero, bus.flag_carry}); end
    checks++; if ({bus.rf_read_p_1, bus.rf_read_p_2, bus.rf_write_p, bus.rf_write_data} !== 17'd0) begin errors++; $display("FAIL reset_addr_data got=%h exp=0", {bus.rf_read_p_1, bus.rf_read_p_2, bus.rf_write_p, bus.rf_write_data}); end
    checks++; if (dbg_state !== 2'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
    reset = 1'b0;
    @(negedge clk);
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL reset_release_ready got=%b exp=1", bus.instr_ready); end
  endtask

  task automatic test_ldi_add;
    int busy;
    int d0;
    d0 = done_cnt;
    run_instr(ldi(3'd1, 8'h0F), 1'b0, busy);
    checks++; if (busy !== 1) begin errors++; $display("FAIL ldi_latency got=%0d exp=1", busy); end
    checks++; if (regs[1] !== 8'h0F) begin errors++; $display("FAIL ldi_r1 got=%h exp=0f", regs[1]); end
    run_instr(ldi(3'd2, 8'hF1), 1'b0, busy);
    checks++; if (regs[2] !== 8'hF1) begin errors++; $display("FAIL ldi_r2 got=%h exp=f1", regs[2]); end
    run_instr(alu(3'b001, 3'd3, 3'd1, 3'd2), 1'b0, busy);
    checks++; if (busy !== 3) begin errors++; $display("FAIL add_latency got=%0d exp=3", busy); end
    checks++; if (regs[3] !== 8'h00) begin errors++; $display("FAIL add_r3 got=%h exp=00", regs[3]); end
    checks++; if ({bus.flag_zero, bus.flag_carry} !== 2'b11) begin errors++; $display("FAIL add_flags got=%b exp=11", {bus.flag_zero, bus.flag_carry}); end
    checks++; if (done_cnt - d0 !== 3) begin errors++; $display("FAIL add_done_pulses got=%0d exp=3", done_cnt - d0); end
  endtask

  task automatic test_sub;
    int busy;
    run_instr(alu(3'b010, 3'd4, 3'd1, 3'd2), 1'b0, busy);
    checks++; if (regs[4] !== 8'h1E) begin errors++; $display("FAIL sub_r4 got=%h exp=1e", regs[4]); end
    checks++; if ({bus.flag_zero, bus.flag_carry} !== 2'b01) begin errors++; $display("FAIL sub_flags got=%b exp=01", {bus.flag_zero, bus.flag_carry}); end
    checks++; if (iss_wp !== 3'd0) begin errors++; $display("FAIL sub_issue_wp got=%0d exp=0", iss_wp); end
  endtask

  task automatic test_overlap;
    int busy;
    run_instr(ldi(3'd0, 8'h05), 1'b0, busy);
    run_instr(ldi(3'd1, 8'h03), 1'b0, busy);
    run_instr(alu(3'b001, 3'd0, 3'd0, 3'd1), 1'b0, busy);
    checks++; if (iss_wp !== 3'd2) begin errors++; $display("FAIL overlap_issue_wp got=%0d exp=2", iss_wp); end
    checks++; if (regs[0] !== 8'h08) begin errors++; $display("FAIL overlap_r0 got=%h exp=08", regs[0]); end
    checks++; if ({bus.flag_zero, bus.flag_carry} !== 2'b00) begin errors++; $display("FAIL overlap_flags got=%b exp=00", {bus.flag_zero, bus.flag_carry}); end
  endtask

  task automatic test_mov;
    int busy;
    run_instr(ldi(3'd1, 8'h0F), 1'b0, busy);
    run_instr(alu(3'b001, 3'd3, 3'd1, 3'd2), 1'b0, busy);
    run_instr(ldi(3'd3, 8'h5C), 1'b0, busy);
    run_instr(alu(3'b111, 3'd7, 3'd3, 3'd0), 1'b0, busy);
    checks++; if (regs[7] !== 8'h5C) begin errors++; $display("FAIL mov_r7 got=%h exp=5c", regs[7]); end
    checks++; if ({bus.flag_zero, bus.flag_carry} !== 2'b11) begin errors++; $display("FAIL mov_flags_hold got=%b exp=11", {bus.flag_zero, bus.flag_carry}); end
    checks++; if ({iss_r1, iss_r2} !== 2'b10) begin errors++; $display("FAIL mov_issue_enables got=%b exp=10", {iss_r1, iss_r2}); end
    checks++; if (iss_p1 !== 3'd3) begin errors++; $display("FAIL mov_issue_p1 got=%0d exp=3", iss_p1); end
    checks++; if (iss_wp !== 3'd1) begin errors++; $display("FAIL mov_issue_wp got=%0d exp=1", iss_wp); end
  endtask

  task automatic test_hold;
    int busy;
    int d0;
    int w0;
    d0 = done_cnt;
    w0 = w_cnt;
    // r4=0x1E, r1=0x0F -> 0x0F, no borrow
    run_instr(alu(3'b010, 3'd6, 3'd4, 3'd1), 1'b1, busy);
    checks++; if (busy !== 3) begin errors++; $display("FAIL hold_busy got=%0d exp=3", busy); end
    checks++; if (regs[6] !== 8'h0F) begin errors++; $display("FAIL hold_r6 got=%h exp=0f", regs[6]); end
    checks++; if (done_cnt - d0 !== 1 || w_cnt - w0 !== 1) begin errors++; $display("FAIL hold_single_exec got done=%0d w=%0d exp 1 1", done_cnt - d0, w_cnt - w0); end
    checks++; if ({bus.flag_zero, bus.flag_carry} !== 2'b00) begin errors++; $display("FAIL hold_flags got=%b exp=00", {bus.flag_zero, bus.flag_carry}); end
  endtask

  task automatic test_reset_mid;
    int busy;
    int w0;
    bit seen;
    w0 = w_cnt;
    seen = 1'b0;
    bus.instr_valid = 1'b1;
    bus.instr       = alu(3'b001, 3'd5, 3'd1, 3'd2);
    @(posedge clk);
    #1 bus.instr_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (dbg_state == 2'd2) begin seen = 1'b1; break; end
    end
    checks++; if (seen !== 1'b1) begin errors++; $display("FAIL midreset_reach_exec got=%b exp=1", seen); end
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++; if (w_cnt - w0 !== 0) begin errors++; $display("FAIL midreset_no_write got=%0d exp=0", w_cnt - w0); end
    checks++; if ({bus.flag_zero, bus.flag_carry} !== 2'b00) begin errors++; $display("FAIL midreset_flags got=%b exp=00", {bus.flag_zero, bus.flag_carry}); end
    checks++; if (regs[5] !== 8'hEE) begin errors++; $display("FAIL midreset_r5 got=%h exp=ee", regs[5]); end
    reset = 1'b0;
    #1;
    checks++; if (bus.instr_ready !== 1'b1) begin errors++; $display("FAIL midreset_ready got=%b exp=1", bus.instr_ready); end
    run_instr(ldi(3'd5, 8'hAA), 1'b0, busy);
    checks++; if (regs[5] !== 8'hAA || busy !== 1) begin errors++; $display("FAIL midreset_ldi got r5=%h busy=%0d exp aa 1", regs[5], busy); end
  endtask

  task automatic test_back_to_back;
    int busy;
    int d0;
    time t0;
    d0 = done_cnt;
    t0 = $time;
    run_instr(ldi(3'd2, 8'h11), 1'b0, busy);
    run_instr(ldi(3'd3, 8'h22), 1'b0, busy);
    run_instr(16'h0000, 1'b0, busy);
    checks++; if ($time - t0 !== 60) begin errors++; $display("FAIL b2b_time got=%0t exp=60", $time - t0); end
    checks++; if (regs[2] !== 8'h11 || regs[3] !== 8'h22) begin errors++; $display("FAIL b2b_regs got=%h %h exp=11 22", regs[2], regs[3]); end
    checks++; if (done_cnt - d0 !== 3) begin errors++; $display("FAIL b2b_done got=%0d exp=3", done_cnt - d0); end
  endtask

  // ---- sequence + report ----
  initial begin
    test_reset();
    test_ldi_add();
    test_sub();
    test_overlap();
    test_mov();
    test_hold();
    test_reset_mid();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule
